// File: rtl/reg_mst_pkg.sv
// Shared types and defaults for the register-network master.
package reg_mst_pkg;

    localparam int unsigned WDT_CYCLES_DEF = 255;
    localparam int unsigned REQ_ADDR_W     = 64;
    localparam int unsigned REQ_DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mst_state_e;

    // Request held toward reg_block_1 from req_vld until the next request.
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wr_data;
        logic                  wr_en;
        logic                  rd_en;
    } reg_req_t;

    function automatic logic apb_setup(input logic psel, input logic penable);
        return psel & ~penable;
    endfunction

endpackage

// File: rtl/reg_mst_wdt.sv
// Access watchdog: counts from the request cycle, flags timeout at WDT_CYCLES.
module reg_mst_wdt #(
    parameter int unsigned WDT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic timeout
);

    localparam int unsigned CW = (WDT_CYCLES < 1) ? 1 : $clog2(WDT_CYCLES + 1);

    logic          running_q;
    logic [CW-1:0] cnt_q;

    // Count reads 0 in the cycle after start, i.e. the req_vld cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
        end else if (stop) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else if (running_q && (cnt_q != CW'(WDT_CYCLES))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = running_q && (cnt_q == CW'(WDT_CYCLES));

endmodule

// File: rtl/reg_mst_top.sv
// APB slave to reg_native_if master for reg_block_1, with access watchdog.
module reg_mst_top
    import reg_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  reg_top__reg_block_1_req_vld,
    output logic                  reg_top__reg_block_1_wr_en,
    output logic                  reg_top__reg_block_1_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_top__reg_block_1_addr,
    output logic [DATA_WIDTH-1:0] reg_top__reg_block_1_wr_data,
    input  logic                  reg_top__reg_block_1_ack_vld,
    input  logic [DATA_WIDTH-1:0] reg_top__reg_block_1_rd_data,
    input  logic                  clear,
    output logic                  interrupt,
    output logic                  global_sync_reset_out
);

    mst_state_e            state_q, state_d;
    reg_req_t              req_q;
    logic                  req_vld_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;
    logic                  intr_q;
    logic                  gsr_q;

    logic                  setup_evt;
    logic                  ack_evt;
    logic                  to_evt;
    logic                  wdt_timeout;

    assign setup_evt = (state_q == ST_IDLE) && apb_setup(PSEL, PENABLE);
    assign ack_evt   = (state_q == ST_WAIT) && reg_top__reg_block_1_ack_vld;
    // An ack on the timeout cycle takes precedence over the watchdog.
    assign to_evt    = (state_q == ST_WAIT) && wdt_timeout && !reg_top__reg_block_1_ack_vld;

    reg_mst_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .start   (setup_evt),
        .stop    (ack_evt | to_evt),
        .timeout (wdt_timeout)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (setup_evt)          state_d = ST_WAIT;
            ST_WAIT: if (ack_evt || to_evt)  state_d = ST_DONE;
            ST_DONE:                         state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PREADY                       = (state_q == ST_DONE);
        PSLVERR                      = pslverr_q;
        PRDATA                       = prdata_q;
        reg_top__reg_block_1_req_vld = req_vld_q;
        reg_top__reg_block_1_wr_en   = req_vld_q & req_q.wr_en;
        reg_top__reg_block_1_rd_en   = req_vld_q & req_q.rd_en;
        reg_top__reg_block_1_addr    = req_q.addr[ADDR_WIDTH-1:0];
        reg_top__reg_block_1_wr_data = req_q.wr_data[DATA_WIDTH-1:0];
        interrupt                    = intr_q;
        global_sync_reset_out        = gsr_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
        end else begin
            req_vld_q <= setup_evt;
            if (setup_evt) begin
                req_q.addr    <= REQ_ADDR_W'(PADDR);
                req_q.wr_data <= REQ_DATA_W'(PWDATA);
                req_q.wr_en   <= PWRITE;
                req_q.rd_en   <= ~PWRITE;
            end
        end
    end

    // Response registers load on entry to DONE and fall back to 0 after it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            gsr_q     <= 1'b0;
        end else begin
            if (ack_evt && req_q.rd_en) prdata_q <= reg_top__reg_block_1_rd_data;
            else                        prdata_q <= '0;
            pslverr_q <= to_evt;
            gsr_q     <= to_evt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)    intr_q <= 1'b0;
        else if (to_evt) intr_q <= 1'b1;
        else if (clear)  intr_q <= 1'b0;
    end

endmodule

// File: tb/tb_reg_mst_top.sv
// Self-checking bench for reg_mst_top: directed and randomized APB transfers.
module tb_reg_mst_top;

    localparam int WDT = 16;

    logic        PCLK, PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [63:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] PRDATA;
    logic        req_vld, wr_en, rd_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic        ack_vld;
    logic [31:0] rd_data;
    logic        clear, interrupt, gsr;

    int checks = 0;
    int errors = 0;
    bit intr_m = 1'b0;

    reg_mst_top #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(32),
        .WDT_CYCLES(WDT)
    ) dut (
        .PCLK                         (PCLK),
        .PRESETn                      (PRESETn),
        .PSEL                         (PSEL),
        .PENABLE                      (PENABLE),
        .PWRITE                       (PWRITE),
        .PADDR                        (PADDR),
        .PWDATA                       (PWDATA),
        .PREADY                       (PREADY),
        .PSLVERR                      (PSLVERR),
        .PRDATA                       (PRDATA),
        .reg_top__reg_block_1_req_vld (req_vld),
        .reg_top__reg_block_1_wr_en   (wr_en),
        .reg_top__reg_block_1_rd_en   (rd_en),
        .reg_top__reg_block_1_addr    (addr),
        .reg_top__reg_block_1_wr_data (wr_data),
        .reg_top__reg_block_1_ack_vld (ack_vld),
        .reg_top__reg_block_1_rd_data (rd_data),
        .clear                        (clear),
        .interrupt                    (interrupt),
        .global_sync_reset_out        (gsr)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; ack 'delay' cycles after req_vld (large = never), clear pulsed at cycle clr_at.
    task automatic xfer(input bit w, input logic [63:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int delay, input int clr_at);
        int  kexp;
        int  k;
        int  extra;
        bit  err;
        bit  seen;
        err  = (delay > WDT);
        kexp = err ? WDT + 1 : delay + 1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        check("req_vld", req_vld, 1);
        check("wr_en", wr_en, w);
        check("rd_en", rd_en, !w);
        check("addr", addr, a);
        check("wr_data", wr_data, wd);
        PENABLE = 1'b1;
        k = 0; extra = 0; seen = 1'b0;
        while (!seen && k < WDT + 8) begin
            ack_vld = (k == delay);
            rd_data = (k == delay) ? rd : $urandom;
            clear   = (k == clr_at);
            PADDR   = {$urandom, $urandom};
            PWRITE  = $urandom_range(0, 1);
            @(posedge PCLK); #1;
            ack_vld = 1'b0; clear = 1'b0;
            k++;
            if (PREADY) seen = 1'b1;
            else if (req_vld || wr_en || rd_en) extra++;
        end
        if (clr_at >= 0 && clr_at < kexp) intr_m = 1'b0;
        if (err) intr_m = 1'b1;
        check("pready_latency", k, kexp);
        check("prdata", PRDATA, (!w && !err) ? rd : 32'h0);
        check("pslverr", PSLVERR, err);
        check("gsr_pulse", gsr, err);
        check("interrupt", interrupt, intr_m);
        check("single_req", extra, 0);
        check("addr_hold", addr, a);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("pready_one_cycle", PREADY, 0);
        check("prdata_after", PRDATA, 0);
        check("pslverr_after", PSLVERR, 0);
        check("gsr_after", gsr, 0);
        check("interrupt_after", interrupt, intr_m);
    endtask

    initial begin
        int  d;
        int  c;
        int  kx;
        bit  stray;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ack_vld = 1'b0; rd_data = '0; clear = 1'b0;
        #1;
        check("rst_pready", PREADY, 0);
        check("rst_req_vld", req_vld, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_gsr", gsr, 0);
        check("rst_addr", addr, 0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        xfer(1'b1, 64'h4, 32'h1111_1111, 32'h0, 6, -1);
        xfer(1'b0, 64'h0, 32'h0, 32'h2222_2222, 3, -1);
        xfer(1'b0, 64'h10, 32'h0, 32'hA5A5_0F0F, 0, -1);
        xfer(1'b1, 64'h20, 32'hDEAD_BEEF, 32'h0, 1000, -1);

        repeat (3) @(posedge PCLK);
        #1 check("interrupt_held", interrupt, 1);
        clear = 1'b1;
        @(posedge PCLK); #1;
        clear = 1'b0;
        intr_m = 1'b0;
        check("interrupt_cleared", interrupt, 0);

        xfer(1'b0, 64'h30, 32'h0, 32'h1234_5678, 1000, WDT);
        xfer(1'b0, 64'h38, 32'h0, 32'h0BAD_F00D, WDT, -1);
        clear = 1'b1;
        @(posedge PCLK); #1;
        clear = 1'b0;
        intr_m = 1'b0;
        xfer(1'b1, 64'h40, 32'h5555_AAAA, 32'h0, WDT, -1);

        for (int i = 0; i < 30; i++) begin
            d  = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, WDT + 2);
            kx = (d > WDT) ? WDT + 1 : d + 1;
            c  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, kx - 1) : -1;
            xfer($urandom_range(0, 1), {$urandom, $urandom}, $urandom, $urandom, d, c);
        end

        // Abort mid-WAIT with reset, then a stray ack must not complete anything.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 64'h8; PWDATA = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        intr_m = 1'b0;
        check("abort_pready", PREADY, 0);
        check("abort_req_vld", req_vld, 0);
        check("abort_addr", addr, 0);
        check("abort_prdata", PRDATA, 0);
        check("abort_interrupt", interrupt, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        ack_vld = 1'b1; rd_data = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        ack_vld = 1'b0;
        stray = 1'b0;
        repeat (WDT + 3) begin
            if (PREADY || req_vld) stray = 1'b1;
            @(posedge PCLK); #1;
        end
        check("stray_ack_ignored", stray, 0);
        xfer(1'b0, 64'hC, 32'h0, 32'h600D_CAFE, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_mst_top.md
# reg_mst_top

Register-network master at the top of the generated register tree. It terminates an APB slave port and converts each APB transfer into a single reg_native_if request to the downstream register slave (reg_block_1). A watchdog bounds every downstream access; a timeout raises a sticky interrupt and a one-cycle global synchronous reset to the downstream tree.

## Interface
- ADDR_WIDTH, 64, APB and native address width
- DATA_WIDTH, 32, APB and native data width
- WDT_CYCLES, 255, cycles allowed from req_vld to ack_vld before timeout
- PCLK  in  1  sole clock
- PRESETn  in  1  reset; one clock; reset is asynchronous and active-low
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  ADDR_WIDTH  APB address
- PWDATA  in  DATA_WIDTH  APB write data
- PREADY  out  1  APB transfer complete
- PSLVERR  out  1  APB error, valid with PREADY
- PRDATA  out  DATA_WIDTH  APB read data, valid with PREADY
- reg_top__reg_block_1_req_vld  out  1  one-cycle request strobe
- reg_top__reg_block_1_wr_en, _rd_en  out  1  access direction, valid with req_vld
- reg_top__reg_block_1_addr  out  ADDR_WIDTH  access address
- reg_top__reg_block_1_wr_data  out  DATA_WIDTH  write data
- reg_top__reg_block_1_ack_vld  in  1  one-cycle completion from downstream
- reg_top__reg_block_1_rd_data  in  DATA_WIDTH  read data, valid with ack_vld
- clear  in  1  synchronous interrupt clear
- interrupt  out  1  sticky timeout flag
- global_sync_reset_out  out  1  one-cycle downstream synchronous reset

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: on PSEL=1, PENABLE=0 (APB setup), register PADDR, PWDATA, PWRITE into addr/wr_data/wr_en/rd_en; assert req_vld next cycle; go to WAIT.
- All addresses forward to reg_block_1; no local decode, no local registers.
- WAIT: watchdog counts from the req_vld cycle. On ack_vld: capture rd_data (reads) or zero (writes) into PRDATA, PSLVERR=0, go to DONE. If count reaches WDT_CYCLES without ack: PRDATA=0, PSLVERR=1, set interrupt, pulse global_sync_reset_out, go to DONE.
- DONE: PREADY=1 for exactly one cycle, then IDLE.
- ack_vld outside WAIT is ignored. ack_vld on the timeout cycle: ack wins, no error.
- interrupt stays set until clear=1; a set and clear in the same cycle leaves it set.
- APB signal changes while in WAIT/DONE are ignored.

## Timing
- Reset: every output 0, FSM in IDLE, watchdog 0, interrupt 0.
- req_vld high one cycle, the cycle after APB setup is sampled. wr_en/rd_en high only with req_vld. addr/wr_data hold from req_vld until the next request.
- ack_vld may arrive in the req_vld cycle or any later cycle.
- Minimum transfer: setup (T0), req_vld (T1), ack sampled (T1), PREADY (T2).
- PRDATA/PSLVERR are registered and valid only while PREADY=1. PRDATA returns to 0 afterwards.
- global_sync_reset_out is registered, one cycle, concurrent with PREADY of the errored transfer.
- PRESETn low mid-transfer aborts immediately to IDLE with all outputs 0. A late ack after reset is ignored.

## Structure
- Shared package: FSM state enum, WDT_CYCLES default constant, native-if request struct (addr, wr_data, wr_en, rd_en).
- One sub-module, reg_mst_wdt: watchdog counter with start/stop inputs and a timeout output, parameterized by WDT_CYCLES.

## Test plan
- Write addr 0x4, data 0x1111_1111; downstream acks 6 cycles after req_vld -> exactly one req_vld with wr_en=1, addr=0x4, wr_data=0x1111_1111; PREADY once; PSLVERR=0.
- Read addr 0x0; downstream acks with rd_data 0x2222_2222 -> rd_en=1, PRDATA=0x2222_2222 during PREADY; PRDATA=0 after.
- Ack in the same cycle as req_vld -> PREADY on the next cycle (two-cycle minimum transfer).
- No ack -> at WDT_CYCLES: PSLVERR=1, PRDATA=0, interrupt=1 (held), global_sync_reset_out pulses once. Pulse clear -> interrupt=0. Clear in the timeout cycle -> interrupt stays 1.
- Ack arriving on the exact timeout cycle -> normal completion, no error, no interrupt.
- Assert PRESETn=0 while in WAIT -> outputs 0 immediately. A stray ack after release produces no PREADY. The next transfer completes normally.
